// File: rtl/apb_master_n.sv
// APB requester bridging a single-cycle transfer request onto NUM_SLV decoded
// completers, with wait-state timeout and back-to-back chaining.
module apb_master_n #(
  parameter int unsigned NUM_SLV   = 4,
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned SPAN_BITS = 12,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  output logic [31:0]               PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [DATA_W/8-1:0]       PSTRB,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  input  logic                      transfer,
  input  logic                      write,
  input  logic [31:0]               addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       wstrb,
  output logic                      ready,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic                      busy
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + (33'(NUM_SLV) << SPAN_BITS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [31:0]       paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic              hit_q, hit_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  wait_q, wait_d;

  logic              sel_ready, sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic [31:0]       offset_c;
  logic              hit_c, done, accept, timeout;

  // Mux the selected completer's response; unselected ones never contribute.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    PSEL      = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (hit_q && idx_q == IDX_W'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_W +: DATA_W];
        PSEL[i]   = (state_q != IDLE);
      end
    end
  end

  assign offset_c = addr - BASE_ADDR;
  assign hit_c    = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < WIN_END);

  // An unmapped access has nobody to answer, so it completes in its first ACCESS cycle.
  assign timeout = (wait_q == CNT_W'(TIMEOUT - 1)) && !sel_ready;
  assign done    = (state_q == ACCESS) && (!hit_q || sel_ready || timeout);
  assign accept  = transfer && ((state_q == IDLE) || done);

  assign ready   = done;
  assign err     = done && (!hit_q || !sel_ready || sel_err);
  assign rdata   = (done && hit_q && sel_ready && !pwrite_q) ? sel_rdata : '0;
  assign busy    = (state_q != IDLE);
  assign PENABLE = (state_q == ACCESS);
  assign PWRITE  = pwrite_q && (state_q != IDLE);
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PSTRB   = pstrb_q;

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    pstrb_d  = pstrb_q;
    hit_d    = hit_q;
    idx_d    = idx_q;
    wait_d   = wait_q;

    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (accept) state_d = SETUP;
               else if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == SETUP) wait_d = '0;
    else if (state_q == ACCESS && !sel_ready && !done) wait_d = wait_q + CNT_W'(1);

    if (accept) begin
      paddr_d  = addr;
      pwdata_d = wdata;
      pwrite_d = write;
      pstrb_d  = write ? wstrb : '0;
      hit_d    = hit_c;
      idx_d    = IDX_W'(offset_c >> SPAN_BITS);
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= '0;
      hit_q    <= 1'b0;
      idx_q    <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      pstrb_q  <= pstrb_d;
      hit_q    <= hit_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
    end
  end

endmodule

// File: tb/tb_apb_master_n.sv
// Randomised bench for apb_master_n: each transaction's cycle-exact behaviour is
// predicted from the address map, chosen wait count and timeout rule.
`timescale 1ns/1ps
module tb_apb_master_n;

  localparam int unsigned NS   = 4;
  localparam int unsigned DW   = 32;
  localparam longint      BASE = 64'h1000_0000;
  localparam int unsigned SB   = 12;
  localparam int unsigned TO   = 16;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [31:0]     PADDR;
  logic [DW-1:0]   PWDATA;
  logic            PWRITE, PENABLE;
  logic [DW/8-1:0] PSTRB;
  logic [NS-1:0]   PSEL;
  logic [NS*DW-1:0] PRDATA;
  logic [NS-1:0]   PREADY, PSLVERR;
  logic            transfer, write;
  logic [31:0]     addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            ready, err, busy;
  logic [DW-1:0]   rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          waits;
    bit          slverr;
    logic [31:0] rd;
  } req_t;

  apb_master_n #(.NUM_SLV(NS), .DATA_W(DW), .BASE_ADDR(32'h1000_0000),
                 .SPAN_BITS(SB), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PENABLE(PENABLE), .PSTRB(PSTRB), .PSEL(PSEL),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .ready(ready), .rdata(rdata), .err(err), .busy(busy));

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit map_hit(input logic [31:0] a);
    longint ua = longint'(a);
    return (ua >= BASE) && (ua < BASE + longint'(NS) * (64'd1 << SB));
  endfunction

  function automatic int map_idx(input logic [31:0] a);
    return int'((longint'(a) - BASE) / (64'd1 << SB));
  endfunction

  task automatic drive_req(input req_t r);
    transfer = 1'b1;
    write    = r.wr;
    addr     = r.a;
    wdata    = r.wd;
    wstrb    = r.ws;
  endtask

  // Completer responses: noise everywhere, the addressed completer follows the plan.
  task automatic drive_bus(input req_t r, input int k);
    for (int i = 0; i < NS; i++) PRDATA[i*DW +: DW] = $urandom;
    PREADY  = NS'($urandom);
    PSLVERR = NS'($urandom);
    if (map_hit(r.a)) begin
      PRDATA[map_idx(r.a)*DW +: DW] = r.rd;
      PSLVERR[map_idx(r.a)] = r.slverr;
      if (k > 0) PREADY[map_idx(r.a)] = (k == r.waits + 1);
    end
  endtask

  task automatic run(input req_t r, input bit pre_issued, input bit chain, input req_t nxt);
    bit          hit = map_hit(r.a);
    logic [3:0]  esel = hit ? 4'(1 << map_idx(r.a)) : 4'h0;
    int          n;
    bit          eerr;
    logic [31:0] erd;
    if (!hit) begin
      n = 1; eerr = 1'b1; erd = 32'h0;
    end else if (r.waits >= int'(TO)) begin
      n = TO; eerr = 1'b1; erd = 32'h0;
    end else begin
      n = r.waits + 1; eerr = r.slverr; erd = r.wr ? 32'h0 : r.rd;
    end
    if (!pre_issued) begin
      @(negedge PCLK);
      drive_req(r);
      drive_bus(r, 0);
    end
    @(negedge PCLK);
    transfer = 1'b0;
    drive_bus(r, 0);
    #1;
    check_eq("setup_psel", 64'(PSEL), 64'(esel));
    check_eq("setup_penable", 64'(PENABLE), 64'd0);
    check_eq("setup_ready", 64'(ready), 64'd0);
    check_eq("setup_busy", 64'(busy), 64'd1);
    check_eq("setup_paddr", 64'(PADDR), 64'(r.a));
    check_eq("setup_pwrite", 64'(PWRITE), 64'(r.wr));
    check_eq("setup_pstrb", 64'(PSTRB), 64'(r.wr ? r.ws : 4'h0));
    check_eq("setup_pwdata", 64'(PWDATA), 64'(r.wd));
    for (int k = 1; k <= n; k++) begin
      @(negedge PCLK);
      drive_bus(r, k);
      if (k == n && chain) drive_req(nxt);
      #1;
      check_eq("acc_psel", 64'(PSEL), 64'(esel));
      check_eq("acc_penable", 64'(PENABLE), 64'd1);
      check_eq("acc_ready", 64'(ready), 64'(k == n));
      check_eq("acc_paddr", 64'(PADDR), 64'(r.a));
      check_eq("acc_pstrb", 64'(PSTRB), 64'(r.wr ? r.ws : 4'h0));
      if (k == n) begin
        check_eq("done_err", 64'(err), 64'(eerr));
        check_eq("done_rdata", 64'(rdata), 64'(erd));
      end else begin
        check_eq("wait_err", 64'(err), 64'd0);
        check_eq("wait_rdata", 64'(rdata), 64'd0);
      end
    end
    if (!chain) begin
      @(negedge PCLK);
      drive_bus(r, 0);
      #1;
      check_eq("idle_busy", 64'(busy), 64'd0);
      check_eq("idle_psel", 64'(PSEL), 64'd0);
      check_eq("idle_penable", 64'(PENABLE), 64'd0);
      check_eq("idle_pwrite", 64'(PWRITE), 64'd0);
      check_eq("idle_ready", 64'(ready), 64'd0);
      check_eq("idle_paddr_hold", 64'(PADDR), 64'(r.a));
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    int   m = int'($urandom_range(0, 9));
    r.wr     = 1'($urandom);
    r.wd     = $urandom;
    r.ws     = 4'($urandom);
    r.rd     = $urandom;
    r.slverr = ($urandom_range(0, 3) == 0);
    r.waits  = ($urandom_range(0, 6) == 0) ? int'($urandom_range(TO - 1, TO + 2))
                                           : int'($urandom_range(0, 4));
    case (m)
      0:       r.a = 32'(BASE - 1 - longint'($urandom_range(0, 255)));
      1:       r.a = 32'(BASE + longint'(NS << SB) + longint'($urandom_range(0, 15)));
      2:       r.a = $urandom | 32'h8000_0000;
      default: r.a = 32'(BASE + longint'($urandom_range(0, NS - 1) << SB)
                         + longint'($urandom_range(0, 4095)));
    endcase
    return r;
  endfunction

  initial begin
    req_t r, r2;
    PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    PRDATA = '0; PREADY = '0; PSLVERR = '0;
    #1;
    check_eq("rst_psel", 64'(PSEL), 64'd0);
    check_eq("rst_paddr", 64'(PADDR), 64'd0);
    check_eq("rst_pwdata", 64'(PWDATA), 64'd0);
    check_eq("rst_pstrb", 64'(PSTRB), 64'd0);
    check_eq("rst_busy_ready_err", 64'({busy, ready, err, PENABLE, PWRITE}), 64'd0);
    @(negedge PCLK); @(negedge PCLK);
    PRESET = 1'b0;

    r = '{wr:1'b1, a:32'h1000_1004, wd:32'hDEAD_BEEF, ws:4'hF, waits:0, slverr:1'b0, rd:32'h0};
    run(r, 1'b0, 1'b0, r);
    r = '{wr:1'b0, a:32'h1000_2000, wd:32'h0, ws:4'hF, waits:3, slverr:1'b0, rd:32'h1234_5678};
    run(r, 1'b0, 1'b0, r);
    r = '{wr:1'b0, a:32'h2000_0000, wd:32'h0, ws:4'h0, waits:0, slverr:1'b0, rd:32'h5555_AAAA};
    run(r, 1'b0, 1'b0, r);
    r = '{wr:1'b1, a:32'h1000_3000, wd:32'hCAFE_0003, ws:4'h3, waits:99, slverr:1'b0, rd:32'h0};
    run(r, 1'b0, 1'b0, r);
    r  = '{wr:1'b1, a:32'h1000_0008, wd:32'h0000_1111, ws:4'h1, waits:0, slverr:1'b0, rd:32'h0};
    r2 = '{wr:1'b0, a:32'h1000_3ffc, wd:32'h0, ws:4'h0, waits:0, slverr:1'b1, rd:32'h8765_4321};
    run(r, 1'b0, 1'b1, r2);
    run(r2, 1'b1, 1'b0, r2);

    // Reset during a stalled ACCESS phase.
    r = '{wr:1'b1, a:32'h1000_0010, wd:32'h7777_0000, ws:4'hC, waits:99, slverr:1'b0, rd:32'h0};
    @(negedge PCLK); drive_req(r); drive_bus(r, 0);
    @(negedge PCLK); transfer = 1'b0; drive_bus(r, 0);
    @(negedge PCLK); drive_bus(r, 1);
    @(negedge PCLK); drive_bus(r, 2);
    #1; PRESET = 1'b1; #1;
    check_eq("mid_rst_psel", 64'(PSEL), 64'd0);
    check_eq("mid_rst_addr_data", 64'({PADDR, PWDATA}), 64'd0);
    check_eq("mid_rst_pstrb", 64'(PSTRB), 64'd0);
    check_eq("mid_rst_ctl", 64'({busy, ready, err, PENABLE, PWRITE}), 64'd0);
    check_eq("mid_rst_rdata", 64'(rdata), 64'd0);
    @(negedge PCLK);
    check_eq("mid_rst_noready", 64'(ready), 64'd0);
    PRESET = 1'b0;
    r = '{wr:1'b0, a:32'h1000_0020, wd:32'h0, ws:4'h0, waits:1, slverr:1'b0, rd:32'h0BAD_F00D};
    run(r, 1'b0, 1'b0, r);

    r = rand_req();
    for (int t = 0; t < 80; t++) begin
      bit c = ($urandom_range(0, 2) == 0);
      r2 = rand_req();
      run(r, 1'b0, c, r2);
      if (c) run(r2, 1'b1, 1'b0, r2);
      r = rand_req();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
